ascon_perm_seq: RTL and testbench

ASCON_PERM_SEQ -- requirements
Module: ascon_perm_seq

---
 rtl/ascon_pack.sv | 30 +++
 rtl/pc.sv | 19 +
 rtl/perm_round.sv | 29 ++
 rtl/pl.sv | 18 +
 rtl/ps.sv | 33 +++
 rtl/ascon_perm_seq.sv | 82 ++++++++
 tb/tb_ascon_perm_seq.sv | 244 ++++++++++++++++++++++++
 7 files changed

// File: rtl/ascon_pack.sv
// Shared types and constants for the sequential Ascon permutation.
package ascon_pack;

    // Five 64-bit lanes; x0 is the first word of a {S0,S1,S2,S3,S4} concatenation.
    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } type_state;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } type_fsm;

    localparam int          ROUNDS_A     = 12;
    localparam int          ROUNDS_B     = 6;
    localparam logic [3:0]  LAST_ROUND   = 4'd11;
    // Both variants end on round 11, so the shorter one starts later.
    localparam logic [3:0]  FIRST_ROUND_A = 4'(int'(LAST_ROUND) + 1 - ROUNDS_A);
    localparam logic [3:0]  FIRST_ROUND_B = 4'(int'(LAST_ROUND) + 1 - ROUNDS_B);

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

endpackage

// File: rtl/pc.sv
// Constant addition: round constant XORed into the low byte of x2.
module pc
    import ascon_pack::*;
(
    input  type_state  state,
    input  logic [3:0] round,
    output type_state  state_out
);

    logic [7:0] rc;

    // Constant is {15-r, r}; only lane x2 is touched.
    always_comb begin
        rc                 = {4'd15 - round, round};
        state_out          = state;
        state_out.x2[7:0]  = state.x2[7:0] ^ rc;
    end

endmodule

// File: rtl/perm_round.sv
// One full Ascon round, purely combinational: pc -> ps -> pl.
module perm_round
    import ascon_pack::*;
(
    input  type_state  state,
    input  logic [3:0] round,
    output type_state  state_out
);

    type_state after_pc;
    type_state after_ps;

    pc u_pc (
        .state     (state),
        .round     (round),
        .state_out (after_pc)
    );

    ps u_ps (
        .state     (after_pc),
        .state_out (after_ps)
    );

    pl u_pl (
        .state     (after_ps),
        .state_out (state_out)
    );

endmodule

// File: rtl/pl.sv
// Linear diffusion layer: each lane XORed with two rotations of itself.
module pl
    import ascon_pack::*;
(
    input  type_state state,
    output type_state state_out
);

    // Per-lane rotation amounts are fixed by the Ascon definition.
    always_comb begin
        state_out.x0 = state.x0 ^ rotr(state.x0, 19) ^ rotr(state.x0, 28);
        state_out.x1 = state.x1 ^ rotr(state.x1, 61) ^ rotr(state.x1, 39);
        state_out.x2 = state.x2 ^ rotr(state.x2, 1)  ^ rotr(state.x2, 6);
        state_out.x3 = state.x3 ^ rotr(state.x3, 10) ^ rotr(state.x3, 17);
        state_out.x4 = state.x4 ^ rotr(state.x4, 7)  ^ rotr(state.x4, 41);
    end

endmodule

// File: rtl/ps.sv
// Substitution layer: the 5-bit Ascon S-box applied bit-sliced across all lanes.
module ps
    import ascon_pack::*;
(
    input  type_state state,
    output type_state state_out
);

    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;

    // Bit-sliced S-box: input mix, chi-like nonlinear step, output mix.
    always_comb begin
        a0 = state.x0 ^ state.x4;
        a1 = state.x1;
        a2 = state.x2 ^ state.x1;
        a3 = state.x3;
        a4 = state.x4 ^ state.x3;

        b0 = a0 ^ (~a1 & a2);
        b1 = a1 ^ (~a2 & a3);
        b2 = a2 ^ (~a3 & a4);
        b3 = a3 ^ (~a4 & a0);
        b4 = a4 ^ (~a0 & a1);

        state_out.x0 = b0 ^ b4;
        state_out.x1 = b1 ^ b0;
        state_out.x2 = ~b2;
        state_out.x3 = b3 ^ b2;
        state_out.x4 = b4;
    end

endmodule

// File: rtl/ascon_perm_seq.sv
// Sequential Ascon permutation, one round per clock, p^a (12) or p^b (6).
//
//   state | meaning
//   IDLE  | waiting for start_i; state register holds last result
//   RUN   | one round applied per edge, round counter advancing
//   DONE  | single-cycle result strobe, then back to IDLE
module ascon_perm_seq
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       rounds_i,
    input  type_state  state_i,
    output type_state  state_o,
    output logic [3:0] round_o,
    output logic       busy_o,
    output logic       done_o
);

    type_fsm    fsm, fsm_nxt;
    type_state  st, st_nxt;
    type_state  round_out;
    logic [3:0] rnd, rnd_nxt;

    perm_round u_round (
        .state     (st),
        .round     (rnd),
        .state_out (round_out)
    );

    // All registers; reset wins over everything, including a start on the same edge.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm <= IDLE;
            st  <= '0;
            rnd <= 4'd0;
        end else begin
            fsm <= fsm_nxt;
            st  <= st_nxt;
            rnd <= rnd_nxt;
        end
    end

    // Next-state, datapath select and status outputs.
    always_comb begin
        fsm_nxt = fsm;
        st_nxt  = st;
        rnd_nxt = rnd;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (fsm)
            IDLE: begin
                if (start_i) begin
                    fsm_nxt = RUN;
                    st_nxt  = state_i;
                    rnd_nxt = rounds_i ? FIRST_ROUND_B : FIRST_ROUND_A;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                st_nxt = round_out;
                if (rnd == LAST_ROUND) begin
                    fsm_nxt = DONE;
                    rnd_nxt = 4'd0;
                end else begin
                    rnd_nxt = rnd + 4'd1;
                end
            end
            DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    assign state_o = st;
    assign round_o = rnd;

endmodule

// File: tb/tb_ascon_perm_seq.sv
// Directed bench for ascon_perm_seq with an S-box-table reference model.
module tb_ascon_perm_seq;
    import ascon_pack::*;

    logic       clock_i;
    logic       reset_i;
    logic       start_i;
    logic       rounds_i;
    type_state  state_i;
    type_state  state_o;
    logic [3:0] round_o;
    logic       busy_o;
    logic       done_o;

    int checks = 0;
    int errors = 0;

    ascon_perm_seq dut (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .start_i  (start_i),
        .rounds_i (rounds_i),
        .state_i  (state_i),
        .state_o  (state_o),
        .round_o  (round_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [63:0] rr(input logic [63:0] v, input int n);
        logic [127:0] t;
        t = {v, v} >> n;
        return t[63:0];
    endfunction

    // Reference permutation: rounds first..11 using the S-box lookup table.
    function automatic type_state model_perm(input type_state s, input int first);
        logic [63:0] w [5];
        logic [4:0]  idx;
        logic [4:0]  o;
        type_state   res;
        w[0] = s.x0; w[1] = s.x1; w[2] = s.x2; w[3] = s.x3; w[4] = s.x4;
        for (int r = first; r < 12; r++) begin
            w[2][7:0] = w[2][7:0] ^ 8'(((15 - r) << 4) | r);
            for (int b = 0; b < 64; b++) begin
                idx = {w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]};
                o = SBOX[idx];
                w[0][b] = o[4]; w[1][b] = o[3]; w[2][b] = o[2];
                w[3][b] = o[1]; w[4][b] = o[0];
            end
            w[0] = w[0] ^ rr(w[0], 19) ^ rr(w[0], 28);
            w[1] = w[1] ^ rr(w[1], 61) ^ rr(w[1], 39);
            w[2] = w[2] ^ rr(w[2], 1)  ^ rr(w[2], 6);
            w[3] = w[3] ^ rr(w[3], 10) ^ rr(w[3], 17);
            w[4] = w[4] ^ rr(w[4], 7)  ^ rr(w[4], 41);
        end
        res = {w[0], w[1], w[2], w[3], w[4]};
        return res;
    endfunction

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clock_i);
        @(negedge clock_i);
    endtask

    typedef struct {
        logic       rb;
        type_state  in;
        type_state  exp;
        int         lat;
        int         first;
    } vec_t;

    vec_t vecs [5];

    localparam type_state V_SPEC = {64'h80400c0600000000, 64'h0001020304050607,
                                    64'h08090a0b0c0d0e0f, 64'h0001020304050607,
                                    64'h08090a0b0c0d0e0f};
    localparam type_state V_ALT  = {64'hdeadbeefcafef00d, 64'h0123456789abcdef,
                                    64'hffffffffffffffff, 64'h0000000000000001,
                                    64'h8000000000000000};

    // Starts one permutation from IDLE and checks timing, round sequence and result.
    task automatic run_vec(input int i);
        vec_t v;
        int   done_k;
        bit   seq_ok;
        logic [3:0] round_at_done;
        type_state  res;
        v = vecs[i];
        start_i = 1'b1; rounds_i = v.rb; state_i = v.in;
        step;
        start_i = 1'b0; rounds_i = ~v.rb; state_i = ~v.in;
        check($sformatf("v%0d_first_round", i), round_o, v.first);
        done_k = -1; seq_ok = 1'b1; round_at_done = 4'hf; res = '0;
        for (int k = 1; k <= 40; k++) begin
            step;
            state_i = ~state_i;
            if (done_o) begin
                done_k = k; res = state_o; round_at_done = round_o;
                break;
            end
            if (!busy_o || int'(round_o) != v.first + k) seq_ok = 1'b0;
        end
        check($sformatf("v%0d_latency", i), done_k, v.lat);
        check($sformatf("v%0d_result", i), res, v.exp);
        check($sformatf("v%0d_round_seq", i), seq_ok, 1'b1);
        check($sformatf("v%0d_round_wrap", i), round_at_done, 4'd0);
        step;
        check($sformatf("v%0d_idle_busy", i), {busy_o, done_o}, 2'b00);
        check($sformatf("v%0d_idle_hold", i), state_o, v.exp);
    endtask

    initial begin
        int   nd;
        int   dk [4];
        type_state ds [4];
        type_state exp_a;

        reset_i = 1'b1; start_i = 1'b0; rounds_i = 1'b0; state_i = V_ALT;

        vecs[0] = '{1'b0, V_SPEC, model_perm(V_SPEC, 0), 12, 0};
        vecs[1] = '{1'b1, '0,     model_perm('0, 6),     6,  6};
        vecs[2] = '{1'b0, '0,     model_perm('0, 0),     12, 0};
        vecs[3] = '{1'b1, V_SPEC, model_perm(V_SPEC, 6), 6,  6};
        vecs[4] = '{1'b0, V_ALT,  model_perm(V_ALT, 0),  12, 0};

        @(negedge clock_i);
        step;
        check("reset_state", state_o, '0);
        check("reset_round", round_o, 4'd0);
        check("reset_busy", busy_o, 1'b0);
        check("reset_done", done_o, 1'b0);
        reset_i = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(i);

        // Start pulses during RUN and DONE are ignored and not queued.
        exp_a = model_perm(V_SPEC, 0);
        start_i = 1'b1; rounds_i = 1'b0; state_i = V_SPEC;
        step;
        nd = 0; dk[0] = -1; ds[0] = '0;
        for (int k = 1; k <= 20; k++) begin
            start_i  = (k == 3 || k == 12 || k == 13);
            state_i  = V_ALT;
            rounds_i = 1'b1;
            step;
            if (done_o) begin
                if (nd < 4) begin dk[nd] = k; ds[nd] = state_o; end
                nd++;
            end
        end
        start_i = 1'b0;
        check("busy_start_done_count", nd, 1);
        check("busy_start_latency", dk[0], 12);
        check("busy_start_result", ds[0], exp_a);
        check("busy_start_not_queued", {busy_o, state_o}, {1'b0, exp_a});

        // Reset during round 5 aborts silently; reset outranks start; release edge accepts start.
        start_i = 1'b1; rounds_i = 1'b0; state_i = V_ALT;
        step;
        start_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (round_o == 4'd5) break;
            step;
        end
        check("abort_reached_round5", round_o, 4'd5);
        reset_i = 1'b1;
        step;
        check("abort_state", state_o, '0);
        check("abort_busy_round_done", {busy_o, round_o, done_o}, {1'b0, 4'd0, 1'b0});
        start_i = 1'b1; rounds_i = 1'b1; state_i = V_SPEC;
        step;
        check("reset_over_start", busy_o, 1'b0);
        reset_i = 1'b0;
        step;
        start_i = 1'b0; state_i = V_ALT; rounds_i = 1'b0;
        check("release_accepts_start", {busy_o, round_o}, {1'b1, 4'd6});
        dk[0] = -1; ds[0] = '0;
        for (int k = 1; k <= 20; k++) begin
            step;
            if (done_o) begin dk[0] = k; ds[0] = state_o; break; end
        end
        check("after_abort_latency", dk[0], 6);
        check("after_abort_result", ds[0], model_perm(V_SPEC, 6));
        step;

        // Back-to-back p^b with start held high; second run loads the new state_i.
        start_i = 1'b1; rounds_i = 1'b1; state_i = '0;
        step;
        state_i = V_SPEC;
        nd = 0;
        for (int j = 0; j < 4; j++) begin dk[j] = -100; ds[j] = '0; end
        for (int k = 1; k <= 20; k++) begin
            step;
            if (done_o) begin
                if (nd < 4) begin dk[nd] = k; ds[nd] = state_o; end
                nd++;
            end
            if (nd == 1 && k == dk[0] + 1) begin
                check("b2b_hold_state", state_o, ds[0]);
                check("b2b_idle_gap", busy_o, 1'b0);
            end
            if (nd == 1 && k == dk[0] + 2)
                check("b2b_second_start", {busy_o, round_o}, {1'b1, 4'd6});
        end
        start_i = 1'b0;
        check("b2b_done_count", nd, 2);
        check("b2b_first_latency", dk[0], 6);
        check("b2b_spacing", dk[1] - dk[0], 8);
        check("b2b_first_result", ds[0], model_perm('0, 6));
        check("b2b_second_result", ds[1], model_perm(V_SPEC, 6));
        step;
        step;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
